mole_array_ctrl: RTL and testbench

MOLE_ARRAY_CTRL -- requirements
Module: mole_array_ctrl

---
 rtl/mole_array_ctrl_if.sv | 29 ++
 rtl/mole_array_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mole_array_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mole_array_ctrl_if.sv
// Bus between the game driver and the mole array controller.
// The master side supplies game control, RNG values and player switches.
// The slave side returns the mole display, the score and the event strobes.
interface mole_array_ctrl_if #(
  parameter int NUM_MOLES = 18,
  parameter int SCORE_W   = 8
);
  logic                               start;
  logic [1:0]                         level;
  logic [10:0]                        spawn_ms;
  logic [4:0]                         spawn_idx;
  logic [NUM_MOLES-1:0]               switches;
  logic [NUM_MOLES-1:0]               mole_up;
  logic [SCORE_W-1:0]                 score;
  logic                               hit_pulse;
  logic                               miss_pulse;
  logic [$clog2(NUM_MOLES+1)-1:0]     active_count;
  logic                               game_over;

  modport master (
    output start, level, spawn_ms, spawn_idx, switches,
    input  mole_up, score, hit_pulse, miss_pulse, active_count, game_over
  );

  modport slave (
    input  start, level, spawn_ms, spawn_idx, switches,
    output mole_up, score, hit_pulse, miss_pulse, active_count, game_over
  );
endinterface

// File: rtl/mole_array_ctrl.sv
// Whack-a-mole array controller.
// A game FSM (IDLE/RUN/OVER) runs a millisecond prescaler, a spawn timer
// and one lifetime counter per mole channel. It detects player hits and
// expiries and keeps a saturating score.
// Optional build macro MOLE_MISS_PENALTY_EN: each expiry also takes one
// point off the score, saturating at zero.
// Zero detection on the spawn and lifetime counters acts one cycle after
// the count reaches zero. A spawn therefore shows on the edge after its
// counter empties, and an expiry clears the mole on the edge after its
// lifetime counter empties.
module mole_array_ctrl #(
  parameter int NUM_MOLES   = 18,
  parameter int MAX_ACTIVE  = 3,
  parameter int CLKS_PER_MS = 50000,
  parameter int LIFE_MS     = 1600,
  parameter int GAME_MS     = 30000,
  parameter int SCORE_W     = 8
) (
  input logic              clk,
  input logic              reset,
  mole_array_ctrl_if.slave bus
);
  localparam int CNT_W     = $clog2(NUM_MOLES + 1);
  localparam int IDX_W     = $clog2(NUM_MOLES);
  localparam int PS_W      = $clog2(CLKS_PER_MS + 1);
  localparam int LIFE_W    = $clog2(LIFE_MS + 1);
  localparam int GAME_W    = $clog2(GAME_MS + 1);
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  state_t                               state_q, state_d;
  logic [PS_W-1:0]                      presc_q;
  logic [GAME_W-1:0]                    game_q;
  logic [10:0]                          spawn_q;
  logic [NUM_MOLES-1:0]                 up_q, sw_q;
  logic [NUM_MOLES-1:0][LIFE_W-1:0]     life_q;
  logic [SCORE_W-1:0]                   score_q, score_d;
  logic                                 hit_q, miss_q, over_o;
  logic [NUM_MOLES-1:0]                 rise, hit_vec, exp_vec, spawn_vec;
  logic [CNT_W-1:0]                     active_cnt;
  logic                                 ms_tick, game_end, run_live, spawn_fire;
  logic [10:0]                          spawn_reload;

  assign ms_tick      = (state_q == S_RUN) && (presc_q == PS_W'(CLKS_PER_MS - 1));
  assign game_end     = ms_tick && (game_q == GAME_W'(GAME_MS - 1));
  // Normal in-game cycle: no restart and no final tick on this edge.
  assign run_live     = (state_q == S_RUN) && !bus.start && !game_end;
  assign spawn_reload = (bus.spawn_ms == 11'd0) ? 11'd1 : bus.spawn_ms;
  assign spawn_fire   = run_live && (spawn_q == 11'd0);
  assign active_cnt   = CNT_W'($countones(up_q));
  assign rise         = bus.switches & ~sw_q;

  // Next-state and status decode for the game FSM.
  always_comb begin
    state_d = state_q;
    over_o  = (state_q == S_OVER);
    if (bus.start)                      state_d = S_RUN;
    else if (state_q == S_RUN && game_end) state_d = S_OVER;
  end

  // Game state register; reset overrides start.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Millisecond prescaler: counts only in RUN and restarts on every start.
  always_ff @(posedge clk) begin
    if (reset || bus.start || state_q != S_RUN || ms_tick) presc_q <= '0;
    else                                                   presc_q <= presc_q + 1'b1;
  end

  // Game length counter in ms.
  always_ff @(posedge clk) begin
    if (reset || bus.start) game_q <= '0;
    else if (ms_tick)       game_q <= game_q + 1'b1;
  end

  // Spawn interval timer: reloads from the RNG whenever it empties.
  always_ff @(posedge clk) begin
    if (reset)                spawn_q <= '0;
    else if (bus.start)       spawn_q <= spawn_reload;
    else if (run_live) begin
      if (spawn_q == 11'd0)   spawn_q <= spawn_reload;
      else if (ms_tick)       spawn_q <= spawn_q - 1'b1;
    end
  end

  // Hit and expiry vectors per channel. A hit on the same channel masks the expiry.
  always_comb begin
    hit_vec = '0;
    exp_vec = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      hit_vec[i] = run_live && up_q[i] && rise[i];
      exp_vec[i] = run_live && up_q[i] && !rise[i] && (life_q[i] == '0);
    end
  end

  // Spawn target: first free channel at or above spawn_idx mod NUM_MOLES, with wrap.
  // Only channels that are down now qualify, so moles hit or expiring this cycle cannot respawn.
  always_comb begin
    int   s;
    int   c;
    logic found;
    logic [IDX_W-1:0] idx;
    spawn_vec = '0;
    found     = 1'b0;
    s         = int'(bus.spawn_idx) % NUM_MOLES;
    for (int k = 0; k < NUM_MOLES; k++) begin
      c = s + k;
      if (c >= NUM_MOLES) c = c - NUM_MOLES;
      idx = IDX_W'(c);
      if (!found && !up_q[idx]) begin
        spawn_vec[idx] = 1'b1;
        found          = 1'b1;
      end
    end
    if (!spawn_fire || int'(active_cnt) >= MAX_ACTIVE) spawn_vec = '0;
  end

  // Per-channel lifetime counters; the level is sampled when the mole spawns.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MOLES; i++) begin
      if (reset || !run_live)                             life_q[i] <= '0;
      else if (spawn_vec[i])                              life_q[i] <= LIFE_W'(LIFE_MS >> bus.level);
      else if (up_q[i] && ms_tick && life_q[i] != '0)     life_q[i] <= life_q[i] - 1'b1;
    end
  end

  // Mole display: hits and expiries drop a mole, a spawn raises one.
  always_ff @(posedge clk) begin
    if (reset || !run_live) up_q <= '0;
    else                    up_q <= (up_q & ~hit_vec & ~exp_vec) | spawn_vec;
  end

  // Switch history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) sw_q <= '0;
    else       sw_q <= bus.switches;
  end

  // Score update: hits add, and with the penalty build expiries subtract, saturating both ways.
  always_comb begin
    int sum;
    sum = int'(score_q) + $countones(hit_vec);
`ifdef MOLE_MISS_PENALTY_EN
    sum = sum - $countones(exp_vec);
`endif
    if (sum < 0)              score_d = '0;
    else if (sum > SCORE_MAX) score_d = '1;
    else                      score_d = SCORE_W'(sum);
  end

  // Score register and event strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      hit_q  <= |hit_vec;
      miss_q <= |exp_vec;
      if (bus.start)     score_q <= '0;
      else if (run_live) score_q <= score_d;
    end
  end

  assign bus.mole_up      = up_q;
  assign bus.score        = score_q;
  assign bus.hit_pulse    = hit_q;
  assign bus.miss_pulse   = miss_q;
  assign bus.active_count = active_cnt;
  assign bus.game_over    = over_o;
endmodule

// File: tb/tb_mole_array_ctrl.sv
// Bench for mole_array_ctrl with small timing parameters.
// The reference model works in absolute edge times since game start: each
// spawn and expiry is scheduled as a deadline edge computed from the ms
// grid, rather than by stepping counters.
module tb_mole_array_ctrl;
  localparam int NM   = 4;
  localparam int MAXA = 2;
  localparam int CPM  = 4;
  localparam int LIFE = 8;
  localparam int GMS  = 100;
  localparam int SW   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mole_array_ctrl_if #(.NUM_MOLES(NM), .SCORE_W(SW)) bus ();

  mole_array_ctrl #(
    .NUM_MOLES(NM), .MAX_ACTIVE(MAXA), .CLKS_PER_MS(CPM),
    .LIFE_MS(LIFE), .GAME_MS(GMS), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state.
  int          m_st;        // 0 idle, 1 run, 2 over
  int          m_t;         // edges since the game-start edge
  int          m_spawn_at;
  int          m_exp_at [NM];
  bit [NM-1:0] m_up, m_swq;
  int          m_score;
  bit          m_hit, m_miss;

  function automatic int next_tick(int t);
    return (t / CPM + 1) * CPM;
  endfunction

  // Edge at which a count of n ms, loaded at edge t, is acted on as empty.
  function automatic int deadline(int t, int n);
    return (n == 0) ? t + 1 : next_tick(t) + (n - 1) * CPM + 1;
  endfunction

  task automatic model_edge();
    bit [NM-1:0] rise, hits, exps, nu;
    int nh, nx, act, s, c, smax, ms;
    bit found;
    rise   = bus.switches & ~m_swq;
    m_hit  = 1'b0;
    m_miss = 1'b0;
    smax   = (1 << SW) - 1;
    ms     = (bus.spawn_ms == 0) ? 1 : int'(bus.spawn_ms);
    if (reset) begin
      m_st = 0; m_up = '0; m_score = 0;
    end else if (bus.start) begin
      m_st = 1; m_t = 0; m_up = '0; m_score = 0;
      m_spawn_at = deadline(0, ms);
    end else if (m_st == 1) begin
      m_t++;
      if (m_t == GMS * CPM) begin
        m_st = 2; m_up = '0;
      end else begin
        hits = m_up & rise;
        exps = '0;
        for (int i = 0; i < NM; i++)
          if (m_up[i] && !hits[i] && m_exp_at[i] == m_t) exps[i] = 1'b1;
        nh = $countones(hits);
        nx = $countones(exps);
`ifdef MOLE_MISS_PENALTY_EN
        m_score = m_score + nh - nx;
`else
        m_score = m_score + nh;
`endif
        if (m_score < 0)    m_score = 0;
        if (m_score > smax) m_score = smax;
        m_hit  = (nh > 0);
        m_miss = (nx > 0);
        act = $countones(m_up);
        nu  = m_up & ~hits & ~exps;
        if (m_t == m_spawn_at) begin
          m_spawn_at = deadline(m_t, ms);
          if (act < MAXA) begin
            s = int'(bus.spawn_idx) % NM;
            found = 1'b0;
            for (int k = 0; k < NM; k++) begin
              c = (s + k) % NM;
              if (!found && !m_up[c]) begin
                found = 1'b1;
                nu[c] = 1'b1;
                m_exp_at[c] = deadline(m_t, LIFE >> bus.level);
              end
            end
          end
        end
        m_up = nu;
      end
    end
    m_swq = reset ? '0 : bus.switches;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mole_up",      32'(bus.mole_up),      32'(m_up));
    chk("score",        32'(bus.score),        32'(m_score));
    chk("hit_pulse",    32'(bus.hit_pulse),    32'(m_hit));
    chk("miss_pulse",   32'(bus.miss_pulse),   32'(m_miss));
    chk("active_count", 32'(bus.active_count), 32'($countones(m_up)));
    chk("game_over",    32'(bus.game_over),    32'(m_st == 2));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.level = 2'd0; bus.spawn_ms = 11'd0;
    bus.spawn_idx = 5'd0; bus.switches = '0;
    m_st = 0; m_t = 0; m_spawn_at = 0; m_up = '0; m_swq = '0;
    m_score = 0; m_hit = 0; m_miss = 0;
    for (int i = 0; i < NM; i++) m_exp_at[i] = 0;

    // Reset state.
    run(3);
    chk("rst_up",    32'(bus.mole_up),   32'h0);
    chk("rst_score", 32'(bus.score),     32'h0);
    chk("rst_over",  32'(bus.game_over), 32'h0);
    reset = 1'b0;
    cyc();

    // First spawn lands on channel 1 thirteen edges after start.
    bus.spawn_ms = 11'd3; bus.spawn_idx = 5'd1; bus.level = 2'd0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    run(13);
    chk("first_spawn", 32'(bus.mole_up), 32'h2);
    run(12);
    chk("second_spawn", 32'(bus.mole_up), 32'h6);
    run(12);
    chk("third_dropped", 32'(bus.mole_up), 32'h6);
    chk("active_two", 32'(bus.active_count), 32'd2);
    // Channel 1 expires 32 clocks after it rose.
    run(8);
    chk("expiry_miss", 32'(bus.miss_pulse), 32'd1);
    chk("expiry_up",   32'(bus.mole_up),    32'h4);
    chk("expiry_score", 32'(bus.score),     32'd0);
    run(4);
    chk("respawn_ch1", 32'(bus.mole_up), 32'h6);
    // Hit on channel 1.
    bus.switches = 4'b0010;
    cyc();
    chk("hit_up",    32'(bus.mole_up),   32'h4);
    chk("hit_pulse", 32'(bus.hit_pulse), 32'd1);
    chk("hit_score", 32'(bus.score),     32'd1);
    cyc();
    chk("hit_single", 32'(bus.hit_pulse), 32'd0);
    // Hit coinciding with channel 2 expiry: the hit wins.
    run(5);
    bus.switches = 4'b0110;
    cyc();
    chk("coin_hit",   32'(bus.hit_pulse),  32'd1);
    chk("coin_miss",  32'(bus.miss_pulse), 32'd0);
    chk("coin_score", 32'(bus.score),      32'd2);
    chk("coin_up",    32'(bus.mole_up),    32'h0);
    bus.switches = '0;
    // Run out the game clock.
    run(400 - 57);
    chk("over_flag", 32'(bus.game_over), 32'd1);
    chk("over_up",   32'(bus.mole_up),   32'h0);
    run(3);
    chk("over_hold", 32'(bus.game_over), 32'd1);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("restart_score", 32'(bus.score),     32'd0);
    chk("restart_over",  32'(bus.game_over), 32'd0);

    // Randomized play with restarts and occasional mid-game resets.
    for (int n = 0; n < 8000; n++) begin
      bus.spawn_ms  = 11'($urandom_range(0, 5));
      bus.spawn_idx = 5'($urandom_range(0, 31));
      bus.level     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 3) bus.switches = NM'($urandom);
      bus.start = (m_st != 1) ? ($urandom_range(0, 15) == 0)
                              : ($urandom_range(0, 699) == 0);
      reset = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    reset = 1'b0; bus.start = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
